bit_divider_8: RTL and testbench

- Sequential signed 8-bit divider using shift/subtract (restoring). It is the inverse companion of the team's 8-bit shift-add multiplier and uses the same board-level operator interface.
- ClearA_LoadB clears A and loads the dividend from the switches into B. Run divides B by the switch value S.
- On completion, A holds the remainder and B holds the quotient. Both are shown on the hex displays.

---
 rtl/bit_divider_8.sv | 193 +++++++++++++++++++
 tb/tb_bit_divider_8.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_divider_8.sv
// Sequential signed restoring divider with operator-panel interface.
// A holds the remainder, B the quotient; both mirrored on hex displays.
module bit_divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             DivZero,
  output logic             Ovf,
  output logic [6:0]       Ahex0,
  output logic [6:0]       Ahex1,
  output logic [6:0]       Bhex2,
  output logic [6:0]       Bhex3
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, FIX, HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d, mv_q, mv_d;
  logic             sd_q, sd_d, sv_q, sv_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;
  logic [6:0]       ah0_q, ah1_q, bh2_q, bh3_q;

  logic [WIDTH:0]   ext_b, ext_s, mag_b, mag_s;
  logic [WIDTH:0]   sh_r;
  logic [WIDTH-1:0] sh_q, rem;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] h;
    unique case (n)
      4'h0: h = 7'b1000000;
      4'h1: h = 7'b1111001;
      4'h2: h = 7'b0100100;
      4'h3: h = 7'b0110000;
      4'h4: h = 7'b0011001;
      4'h5: h = 7'b0010010;
      4'h6: h = 7'b0000010;
      4'h7: h = 7'b1111000;
      4'h8: h = 7'b0000000;
      4'h9: h = 7'b0010000;
      4'ha: h = 7'b0001000;
      4'hb: h = 7'b0000011;
      4'hc: h = 7'b1000110;
      4'hd: h = 7'b0100001;
      4'he: h = 7'b0000110;
      default: h = 7'b0001110;
    endcase
    return h;
  endfunction

  // Magnitudes carry one extra bit so the most negative value is exact
  always_comb begin
    ext_b = {b_q[WIDTH-1], b_q};
    ext_s = {S[WIDTH-1], S};
    mag_b = b_q[WIDTH-1] ? -ext_b : ext_b;
    mag_s = S[WIDTH-1] ? -ext_s : ext_s;
    sh_r  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    sh_q  = {q_q[WIDTH-2:0], 1'b0};
    rem   = r_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    mv_d    = mv_q;
    sd_d    = sd_q;
    sv_d    = sv_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (ClearA_LoadB) begin
          a_d   = '0;
          b_d   = S;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
        end else if (Run) begin
          state_d = PREP;
          busy_d  = 1'b1;
        end
      end
      PREP: begin
        if (S == '0) begin
          dz_d    = 1'b1;
          ovf_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = HOLD;
        end else begin
          sd_d    = b_q[WIDTH-1];
          sv_d    = S[WIDTH-1];
          mv_d    = mag_s;
          q_d     = mag_b[WIDTH-1:0];
          r_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (sh_r >= mv_q) begin
          r_d = sh_r - mv_q;
          q_d = sh_q | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          r_d = sh_r;
          q_d = sh_q;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        b_d     = (sd_q ^ sv_q) ? -q_q : q_q;
        a_d     = sd_q ? -rem : rem;
        ovf_d   = (b_q == MIN) && sv_q && (mv_q == 1);
        dz_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      mv_q    <= '0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ah0_q   <= 7'b1000000;
      ah1_q   <= 7'b1000000;
      bh2_q   <= 7'b1000000;
      bh3_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      mv_q    <= mv_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      ah0_q   <= hex7(a_q[3:0]);
      ah1_q   <= hex7(a_q[7:4]);
      bh2_q   <= hex7(b_q[3:0]);
      bh3_q   <= hex7(b_q[7:4]);
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign Busy    = busy_q;
  assign DivZero = dz_q;
  assign Ovf     = ovf_q;
  assign Ahex0   = ah0_q;
  assign Ahex1   = ah1_q;
  assign Bhex2   = bh2_q;
  assign Bhex3   = bh3_q;

endmodule

// File: tb/tb_bit_divider_8.sv
// Randomized scoreboard bench for bit_divider_8.
// Reference is plain signed integer division.
module tb_bit_divider_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       cl = 1'b0;
  logic [7:0] s = 8'h00;
  logic [7:0] a, b;
  logic       busy, dz, ovf;
  logic [6:0] ah0, ah1, bh2, bh3;

  bit_divider_8 #(.WIDTH(8)) dut (
    .Clk(clk), .Reset(rst_n), .Run(run),
    .ClearA_LoadB(cl), .S(s), .A(a), .B(b),
    .Busy(busy), .DivZero(dz), .Ovf(ovf),
    .Ahex0(ah0), .Ahex1(ah1),
    .Bhex2(bh2), .Bhex3(bh3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       dz;
    logic       ov;
    int         bc;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         checks = 0;
  int         fails = 0;
  logic [7:0] ma = 8'h00;
  logic [7:0] mb = 8'h00;
  bit         prev_busy = 1'b0;
  bit         hex_pend = 1'b0;
  int         busy_cnt = 0;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
          7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
          7'h46, 7'h21, 7'h06, 7'h0e};
    return t[n];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a0,
                                 input logic [7:0] b0,
                                 input logic [7:0] d);
    exp_t e;
    int   n, dv;
    n  = int'($signed(b0));
    dv = int'($signed(d));
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.bc = 10;
    if (dv == 0) begin
      e.a  = a0;
      e.b  = b0;
      e.dz = 1'b1;
      e.bc = 1;
    end else if (n == -128 && dv == -1) begin
      e.a  = 8'h00;
      e.b  = 8'h80;
      e.ov = 1'b1;
    end else begin
      e.b = 8'(n / dv);
      e.a = 8'(n % dv);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      hex_pend  = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (hex_pend) begin
        chk("ahex0", 32'(ah0), 32'(seg(cur.a[3:0])));
        chk("ahex1", 32'(ah1), 32'(seg(cur.a[7:4])));
        chk("bhex2", 32'(bh2), 32'(seg(cur.b[3:0])));
        chk("bhex3", 32'(bh3), 32'(seg(cur.b[7:4])));
        hex_pend = 1'b0;
      end
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("rem_a", 32'(a), 32'(cur.a));
          chk("quot_b", 32'(b), 32'(cur.b));
          chk("divzero", 32'(dz), 32'(cur.dz));
          chk("ovf", 32'(ovf), 32'(cur.ov));
          chk("busy_cycles", 32'(busy_cnt), 32'(cur.bc));
          hex_pend = 1'b1;
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    cl = 1'b1;
    s  = v;
    tick();
    cl = 1'b0;
    ma = 8'h00;
    mb = v;
  endtask

  task automatic do_div(input logic [7:0] v,
                        input int hold,
                        input bit noise);
    exp_t e;
    int   n;
    e = model(ma, mb, v);
    sb.push_back(e);
    ma  = e.a;
    mb  = e.b;
    run = 1'b1;
    s   = v;
    tick();
    tick();
    n = 0;
    while (busy && n < 30) begin
      if (noise) begin
        cl = 1'($urandom);
        s  = 8'($urandom);
      end
      tick();
      n++;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (noise) cl = 1'($urandom);
      tick();
    end
    cl  = 1'b0;
    run = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, 32'(a), 32'd0);
    chk({nm, "_b"}, 32'(b), 32'd0);
    chk({nm, "_flags"}, 32'({busy, dz, ovf}), 32'd0);
    chk({nm, "_hex"}, 32'({ah0, ah1, bh2, bh3}),
        32'({7'h40, 7'h40, 7'h40, 7'h40}));
  endtask

  initial begin
    logic [7:0] dvd, dvs;
    int         k;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    do_load(8'h64); do_div(8'h07, 0, 1'b0);
    do_load(8'h9c); do_div(8'h07, 0, 1'b0);
    do_load(8'h64); do_div(8'hf9, 0, 1'b0);
    do_load(8'h64); do_div(8'h00, 0, 1'b0);
    do_load(8'h80); do_div(8'hff, 0, 1'b0);
    do_load(8'h80); do_div(8'h80, 0, 1'b0);
    do_load(8'h07); do_div(8'h03, 40, 1'b1);
    do_load(8'h7f); do_div(8'h01, 2, 1'b1);

    do_load(8'h55);
    do_div(8'h04, 0, 1'b0);
    run = 1'b1;
    s   = 8'h03;
    for (int i = 0; i < 6; i++) tick();
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    run = 1'b0;
    ma  = 8'h00;
    mb  = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    do_load(8'hc8); do_div(8'h05, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      dvd = 8'($urandom);
      k   = int'($urandom_range(0, 9));
      dvs = (k == 0) ? 8'h00 :
            (k == 1) ? 8'hff :
            (k == 2) ? 8'h80 : 8'($urandom);
      if ($urandom_range(0, 9) < 7) do_load(dvd);
      do_div(dvs, int'($urandom_range(0, 3)),
             1'($urandom));
    end

    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
